// File: rtl/comfort_pkg.sv
// Shared types, default thresholds and width helper for the zoned comfort controller.
package comfort_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      HEAT = 2'd1,
      COOL = 2'd2
   } hvac_state_t;

   localparam int DEF_ZONES       = 2;
   localparam int DEF_TEMP_W      = 6;
   localparam int DEF_LUME_W      = 6;
   localparam int DEF_HEAT_ON     = 16;
   localparam int DEF_HEAT_OFF    = 20;
   localparam int DEF_COOL_ON     = 30;
   localparam int DEF_COOL_OFF    = 26;
   localparam int DEF_ECO_OFFSET  = 4;
   localparam int DEF_LUME_ON     = 12;
   localparam int DEF_LUME_OFF    = 15;
   localparam int DEF_HOLD_CYCLES = 8;
   localparam int DEF_MIN_DWELL   = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/comfort_zone.sv
// One comfort zone: occupancy hold counter, HVAC FSM with minimum dwell and light hysteresis latch.
module comfort_zone
   import comfort_pkg::*;
#(
   parameter int TEMP_W      = DEF_TEMP_W,
   parameter int LUME_W      = DEF_LUME_W,
   parameter int HEAT_ON     = DEF_HEAT_ON,
   parameter int HEAT_OFF    = DEF_HEAT_OFF,
   parameter int COOL_ON     = DEF_COOL_ON,
   parameter int COOL_OFF    = DEF_COOL_OFF,
   parameter int ECO_OFFSET  = DEF_ECO_OFFSET,
   parameter int LUME_ON     = DEF_LUME_ON,
   parameter int LUME_OFF    = DEF_LUME_OFF,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int MIN_DWELL   = DEF_MIN_DWELL
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              motion_i,
   input  logic [TEMP_W-1:0] temp_i,
   input  logic [LUME_W-1:0] lume_i,
   output logic              heater_o,
   output logic              cooler_o,
   output logic              light_o,
   output logic              occupied_o,
   output logic              active_next_o
);

   localparam int OCC_W   = (clog2(HOLD_CYCLES + 1) > 0) ? clog2(HOLD_CYCLES + 1) : 1;
   localparam int DWELL_W = (clog2(MIN_DWELL) > 0) ? clog2(MIN_DWELL) : 1;

   typedef logic [TEMP_W:0] temp_ext_t;

   localparam logic [OCC_W-1:0]   HOLD_LOAD  = OCC_W'(HOLD_CYCLES);
   localparam logic [DWELL_W-1:0] DWELL_LOAD = (MIN_DWELL > 0) ? DWELL_W'(MIN_DWELL - 1) : '0;
   localparam temp_ext_t HEAT_ON_T  = temp_ext_t'(HEAT_ON);
   localparam temp_ext_t HEAT_OFF_T = temp_ext_t'(HEAT_OFF);
   localparam temp_ext_t COOL_ON_T  = temp_ext_t'(COOL_ON);
   localparam temp_ext_t COOL_OFF_T = temp_ext_t'(COOL_OFF);
   localparam temp_ext_t ECO_T      = temp_ext_t'(ECO_OFFSET);
   localparam logic [LUME_W-1:0] LUME_ON_T  = LUME_W'(LUME_ON);
   localparam logic [LUME_W-1:0] LUME_OFF_T = LUME_W'(LUME_OFF);

   logic [OCC_W-1:0]   occ_cnt_q, occ_cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   hvac_state_t        state_q, state_d;
   logic               occupied_q, occupied_d;
   logic               heater_q, heater_d;
   logic               cooler_q, cooler_d;
   logic               light_q, light_d;
   temp_ext_t          temp_x;
   temp_ext_t          heat_on_eff, heat_off_eff, cool_on_eff, cool_off_eff;

   assign temp_x = {1'b0, temp_i};

   // Occupancy hold counter; motion reloads, otherwise counts down to zero.
   always_comb begin
      occ_cnt_d = occ_cnt_q;
      if (motion_i) begin
         occ_cnt_d = HOLD_LOAD;
      end else if (occ_cnt_q != '0) begin
         occ_cnt_d = occ_cnt_q - OCC_W'(1);
      end else begin
         occ_cnt_d = occ_cnt_q;
      end
      // The motion term keeps HOLD_CYCLES=0 meaningful as a plain 1-cycle delay.
      occupied_d = motion_i | (occ_cnt_d != '0);
   end

   // Effective thresholds: setback band widens while the zone is unoccupied.
   always_comb begin
      if (occupied_q) begin
         heat_on_eff  = HEAT_ON_T;
         heat_off_eff = HEAT_OFF_T;
         cool_on_eff  = COOL_ON_T;
         cool_off_eff = COOL_OFF_T;
      end else begin
         heat_on_eff  = HEAT_ON_T - ECO_T;
         heat_off_eff = HEAT_OFF_T - ECO_T;
         cool_on_eff  = COOL_ON_T + ECO_T;
         cool_off_eff = COOL_OFF_T + ECO_T;
      end
   end

   // HVAC next state; HEAT and COOL only exit through OFF once dwell expires.
   always_comb begin
      state_d = state_q;
      dwell_d = (dwell_q != '0) ? (dwell_q - DWELL_W'(1)) : dwell_q;
      case (state_q)
         OFF: begin
            if (temp_x < heat_on_eff) begin
               state_d = HEAT;
               dwell_d = DWELL_LOAD;
            end else if (temp_x > cool_on_eff) begin
               state_d = COOL;
               dwell_d = DWELL_LOAD;
            end else begin
               state_d = OFF;
            end
         end
         HEAT: begin
            if ((temp_x >= heat_off_eff) && (dwell_q == '0)) begin
               state_d = OFF;
            end else begin
               state_d = HEAT;
            end
         end
         COOL: begin
            if ((temp_x <= cool_off_eff) && (dwell_q == '0)) begin
               state_d = OFF;
            end else begin
               state_d = COOL;
            end
         end
         default: begin
            state_d = OFF;
            dwell_d = '0;
         end
      endcase
      heater_d = (state_d == HEAT);
      cooler_d = (state_d == COOL);
   end

   // Light latch with hysteresis between LUME_ON and LUME_OFF.
   always_comb begin
      light_d = light_q;
      if (!occupied_q || (lume_i >= LUME_OFF_T)) begin
         light_d = 1'b0;
      end else if (lume_i < LUME_ON_T) begin
         light_d = 1'b1;
      end else begin
         light_d = light_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         occ_cnt_q  <= '0;
         dwell_q    <= '0;
         state_q    <= OFF;
         occupied_q <= 1'b0;
         heater_q   <= 1'b0;
         cooler_q   <= 1'b0;
         light_q    <= 1'b0;
      end else begin
         occ_cnt_q  <= occ_cnt_d;
         dwell_q    <= dwell_d;
         state_q    <= state_d;
         occupied_q <= occupied_d;
         heater_q   <= heater_d;
         cooler_q   <= cooler_d;
         light_q    <= light_d;
      end
   end

   assign heater_o      = heater_q;
   assign cooler_o      = cooler_q;
   assign light_o       = light_q;
   assign occupied_o    = occupied_q;
   assign active_next_o = heater_d | cooler_d | light_d;

endmodule

// File: rtl/comfort_ctrl_zoned.sv
// Multi-zone comfort controller: one comfort_zone per zone plus a registered any_active summary.
module comfort_ctrl_zoned
   import comfort_pkg::*;
#(
   parameter int ZONES       = DEF_ZONES,
   parameter int TEMP_W      = DEF_TEMP_W,
   parameter int LUME_W      = DEF_LUME_W,
   parameter int HEAT_ON     = DEF_HEAT_ON,
   parameter int HEAT_OFF    = DEF_HEAT_OFF,
   parameter int COOL_ON     = DEF_COOL_ON,
   parameter int COOL_OFF    = DEF_COOL_OFF,
   parameter int ECO_OFFSET  = DEF_ECO_OFFSET,
   parameter int LUME_ON     = DEF_LUME_ON,
   parameter int LUME_OFF    = DEF_LUME_OFF,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int MIN_DWELL   = DEF_MIN_DWELL
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ZONES-1:0]         motion_sen,
   input  logic [ZONES*TEMP_W-1:0]  temp_sen,
   input  logic [ZONES*LUME_W-1:0]  lume_sen,
   output logic [ZONES-1:0]         heater,
   output logic [ZONES-1:0]         cooler,
   output logic [ZONES-1:0]         light_high,
   output logic [ZONES-1:0]         occupied,
   output logic                     any_active
);

   if (!((HEAT_ON >= ECO_OFFSET) && (HEAT_ON < HEAT_OFF) && (HEAT_OFF <= COOL_OFF) &&
         (COOL_OFF < COOL_ON) && ((COOL_ON + ECO_OFFSET) < (1 << TEMP_W)))) begin : g_bad_thresholds
      $error("comfort_ctrl_zoned: inconsistent temperature thresholds");
   end

   logic [ZONES-1:0] active_next_s;
   logic             any_active_q, any_active_d;

   for (genvar z = 0; z < ZONES; z++) begin : g_zone
      comfort_zone #(
         .TEMP_W      (TEMP_W),
         .LUME_W      (LUME_W),
         .HEAT_ON     (HEAT_ON),
         .HEAT_OFF    (HEAT_OFF),
         .COOL_ON     (COOL_ON),
         .COOL_OFF    (COOL_OFF),
         .ECO_OFFSET  (ECO_OFFSET),
         .LUME_ON     (LUME_ON),
         .LUME_OFF    (LUME_OFF),
         .HOLD_CYCLES (HOLD_CYCLES),
         .MIN_DWELL   (MIN_DWELL)
      ) u_zone (
         .clk_i         (clk),
         .reset_i       (reset),
         .motion_i      (motion_sen[z]),
         .temp_i        (temp_sen[z*TEMP_W +: TEMP_W]),
         .lume_i        (lume_sen[z*LUME_W +: LUME_W]),
         .heater_o      (heater[z]),
         .cooler_o      (cooler[z]),
         .light_o       (light_high[z]),
         .occupied_o    (occupied[z]),
         .active_next_o (active_next_s[z])
      );
   end

   assign any_active_d = |active_next_s;

   // Summary flag registered on the same edge as the zone outputs it reflects.
   always_ff @(posedge clk) begin
      if (reset) begin
         any_active_q <= 1'b0;
      end else begin
         any_active_q <= any_active_d;
      end
   end

   assign any_active = any_active_q;

endmodule

// File: doc/comfort_ctrl_zoned.md
Name: comfort_ctrl_zoned

Overview:
Parametrised successor to the single-room comfort controller. It drives heater, cooler and light for ZONES independent zones from per-zone motion, temperature and luminance sensors. Each zone adds hysteresis, a minimum-on dwell for HVAC, an occupancy hold timer, and an unoccupied setback (eco) band. The block sits between the sensor front-end and the actuator drivers of the home controller.

Parameters:
ZONES, 2, number of independent zones
TEMP_W, 6, temperature sample width (unsigned, degrees C)
LUME_W, 6, luminance sample width (unsigned)
HEAT_ON, 16, heat starts when temp < HEAT_ON (occupied)
HEAT_OFF, 20, heat stops when temp >= HEAT_OFF (occupied)
COOL_ON, 30, cool starts when temp > COOL_ON (occupied)
COOL_OFF, 26, cool stops when temp <= COOL_OFF (occupied)
ECO_OFFSET, 4, setback applied to all four temperature thresholds when the zone is unoccupied
LUME_ON, 12, light on when lume < LUME_ON
LUME_OFF, 15, light off when lume >= LUME_OFF
HOLD_CYCLES, 8, cycles occupancy persists after the last motion
MIN_DWELL, 4, minimum cycles in HEAT or COOL before leaving; 0 disables the dwell

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
motion_sen  in  ZONES  per-zone motion detect
temp_sen  in  ZONES*TEMP_W  zone z occupies bits [z*TEMP_W +: TEMP_W]
lume_sen  in  ZONES*LUME_W  zone z occupies bits [z*LUME_W +: LUME_W]
heater  out  ZONES  heater enable per zone
cooler  out  ZONES  cooler enable per zone
light_high  out  ZONES  light enable per zone
occupied  out  ZONES  occupancy status per zone
any_active  out  1  OR of all heater, cooler and light_high bits

Behaviour:
- One clock domain is used. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- On reset, every output is 0, every FSM is in OFF, and every counter is 0. Reset asserted mid-operation overrides everything at the next edge, including an HVAC unit in its dwell.
- All outputs are registered. A sensor change sampled at edge N is visible after edge N, giving 1-cycle latency.
- Occupancy counter per zone, width clog2(HOLD_CYCLES+1):
  - motion_sen=1: counter loads HOLD_CYCLES.
  - Otherwise the counter decrements while nonzero.
  - occupied = (counter != 0), registered.
  - HOLD_CYCLES=0: occupied follows motion_sen with 1-cycle delay.
- Effective thresholds use the pre-edge occupied value:
  - Unoccupied: HEAT_ON and HEAT_OFF are lowered by ECO_OFFSET; COOL_ON and COOL_OFF are raised by ECO_OFFSET.
  - Compare in TEMP_W+1 unsigned bits, so no wrap-around.
  - Elaboration check: HEAT_ON >= ECO_OFFSET, HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON, and COOL_ON+ECO_OFFSET < 2^TEMP_W.
- HVAC FSM per zone, states OFF, HEAT, COOL:
  - OFF -> HEAT if temp < heat_on_eff.
  - OFF -> COOL if temp > cool_on_eff. These two conditions are mutually exclusive by the threshold ordering.
  - HEAT -> OFF if temp >= heat_off_eff and dwell == 0.
  - COOL -> OFF if temp <= cool_off_eff and dwell == 0.
  - No direct HEAT<->COOL transition. The FSM always passes through OFF for at least one cycle.
  - Entering HEAT or COOL loads dwell = MIN_DWELL-1 (saturating at 0). Dwell decrements each cycle while nonzero.
  - heater = (state==HEAT); cooler = (state==COOL). heater and cooler are never both 1.
- Light per zone:
  - Turns on when occupied and lume < LUME_ON.
  - Turns off when lume >= LUME_OFF or the zone is unoccupied.
  - Otherwise it holds its value (hysteresis band LUME_ON..LUME_OFF-1).
- Zones are fully independent. Simultaneous events in different zones are processed in the same cycle.
- any_active is registered alongside the other outputs.

Decomposition:
- Shared package comfort_pkg holds:
  - hvac_state_t enum {OFF, HEAT, COOL}, 2 bits.
  - Default threshold constants.
  - The clog2 helper.
- Sub-module comfort_zone holds one zone: the occupancy counter, HVAC FSM, dwell counter and light latch.
- The top level only generates ZONES instances, slices the packed buses and computes any_active.

Test Plan:
- Reset for 2 cycles with arbitrary inputs -> all outputs 0. Assert reset while zone 0 is in HEAT with dwell pending -> heater[0]=0 after the next edge.
- Zone 0: motion=1, temp=14 -> occupied=1, then heater=1 the following cycle. Temp stepped 18 -> heater stays 1. Temp=20 -> heater stays 1 until 4 cycles after HEAT entry, then 0.
- Zone 1: occupied, temp=35 -> cooler=1. Next cycle temp=10 -> cooler holds for the dwell, goes to OFF for one cycle, then heater=1. heater and cooler are never high together.
- Zone 0: motion=1 for one cycle, then 0 -> occupied stays 1 for 8 cycles, then 0. With temp=14, heater=0 while unoccupied (eco heat_on = 12). Temp=11 -> heater=1.
- Light, occupied: lume=11 -> light=1. lume=13 -> light holds 1. lume=15 -> light=0. lume=11 with zone unoccupied -> light=0.
- Both zones stimulated simultaneously (zone 0 cold, zone 1 hot and dark) -> heater=2'b01, cooler=2'b10, light_high=2'b10, any_active=1.
